// File: rtl/multi_dataflow_stream_fifo_bank_if.sv
// ----------------------------------------------------------------------------
// multi_dataflow_stream_fifo_bank_if
// Bundles the per-channel push (producer -> bank) and pop (bank -> engine)
// stream handshakes of the multi_dataflow FIFO bank.
//   push_data  : NB_CH*DATA_WIDTH, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   push_valid : NB_CH, producer valid
//   push_ready : NB_CH, bank ready
//   pop_data   : NB_CH*DATA_WIDTH, head word per channel
//   pop_valid  : NB_CH, bank valid towards the engine
//   pop_ready  : NB_CH, engine ready
// Modports: slave = FIFO bank view, master = environment (source/engine) view.
// ----------------------------------------------------------------------------
interface multi_dataflow_stream_fifo_bank_if #(
  parameter int NB_CH      = 3,
  parameter int DATA_WIDTH = 32
);
  logic [NB_CH*DATA_WIDTH-1:0] push_data;
  logic [NB_CH-1:0]            push_valid;
  logic [NB_CH-1:0]            push_ready;
  logic [NB_CH*DATA_WIDTH-1:0] pop_data;
  logic [NB_CH-1:0]            pop_valid;
  logic [NB_CH-1:0]            pop_ready;

  modport slave (
    input  push_data, push_valid, pop_ready,
    output push_ready, pop_data, pop_valid
  );

  modport master (
    output push_data, push_valid, pop_ready,
    input  push_ready, pop_data, pop_valid
  );
endinterface

// File: rtl/multi_dataflow_stream_fifo_bank.sv
// ----------------------------------------------------------------------------
// multi_dataflow_stream_fifo_bank
// NB_CH independent FIFO channels (FIFO_DEPTH words of DATA_WIDTH bits) with a
// job controller that lets each channel pop exactly len words per job and
// pulses done_o once every channel has delivered its quota.
//
// Ports:
//   clk_i, rst_i (sync, active-high), clear_i (sync soft clear, same as reset)
//   enable_i   : global enable, low blocks push, pop and start
//   start_i    : job start pulse, len_i sampled when accepted in IDLE
//   len_i      : words per channel for the job
//   bus        : stream interface (slave modport), push and pop handshakes
//   full_o     : per-channel FIFO full
//   empty_o    : per-channel FIFO empty
//   busy_o     : job running
//   done_o     : one-cycle job completion pulse
//
// Optional feature: define MDC_FIFO_BANK_FALLTHROUGH_EN to let a word pushed
// into an empty, open channel appear on the pop side in the same cycle (and
// bypass storage when it is popped immediately). Default build: no bypass,
// one cycle minimum latency.
// ----------------------------------------------------------------------------
module multi_dataflow_stream_fifo_bank #(
  parameter int NB_CH      = 3,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  multi_dataflow_stream_fifo_bank_if.slave bus,
  output logic [NB_CH-1:0]     full_o,
  output logic [NB_CH-1:0]     empty_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Storage and control state
  logic [DATA_WIDTH-1:0] r_mem  [NB_CH][FIFO_DEPTH];
  logic [AW-1:0]         r_wptr [NB_CH];
  logic [AW-1:0]         r_rptr [NB_CH];
  logic [AW:0]           r_occ  [NB_CH];
  logic [CNT_WIDTH-1:0]  r_cnt  [NB_CH];
  logic [CNT_WIDTH-1:0]  r_len;
  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;

  // Per-channel combinational handshake decode
  logic [NB_CH-1:0]            w_full, w_empty, w_gate, w_push_rdy, w_push;
  logic [NB_CH-1:0]            w_ft, w_pop_vld, w_pop, w_bypass, w_wr, w_rd;
  logic [NB_CH*DATA_WIDTH-1:0] w_pop_data;
  logic [CNT_WIDTH-1:0]        w_cnt_nxt [NB_CH];
  logic                        w_all_done;

  always_comb begin
    w_full     = '0;
    w_empty    = '0;
    w_gate     = '0;
    w_push_rdy = '0;
    w_push     = '0;
    w_ft       = '0;
    w_pop_vld  = '0;
    w_pop      = '0;
    w_bypass   = '0;
    w_wr       = '0;
    w_rd       = '0;
    w_pop_data = '0;
    w_all_done = 1'b1;
    for (int c = 0; c < NB_CH; c++) begin
      w_full[c]     = (r_occ[c] == (AW+1)'(FIFO_DEPTH));
      w_empty[c]    = (r_occ[c] == '0);
      // Pop gate: channel may deliver only while its job quota is not met.
      w_gate[c]     = enable_i & (r_state == S_RUN) & (r_cnt[c] != r_len);
      // Push readiness ignores pop_ready so a full channel never relies on a
      // same-cycle pop to free a slot.
      w_push_rdy[c] = enable_i & ~w_full[c];
      w_push[c]     = bus.push_valid[c] & w_push_rdy[c];
`ifdef MDC_FIFO_BANK_FALLTHROUGH_EN
      w_ft[c]       = w_empty[c] & bus.push_valid[c] & w_gate[c];
`else
      w_ft[c]       = 1'b0;
`endif
      w_pop_vld[c]  = w_gate[c] & (~w_empty[c] | w_ft[c]);
      w_pop[c]      = w_pop_vld[c] & bus.pop_ready[c];
      // A fall-through word popped in the same cycle never touches storage.
      w_bypass[c]   = w_ft[c] & w_pop[c];
      w_wr[c]       = w_push[c] & ~w_bypass[c];
      w_rd[c]       = w_pop[c] & ~w_bypass[c];
      if (w_ft[c])
        w_pop_data[c*DATA_WIDTH +: DATA_WIDTH] = bus.push_data[c*DATA_WIDTH +: DATA_WIDTH];
      else if (!w_empty[c])
        w_pop_data[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[c][r_rptr[c]];
      w_cnt_nxt[c]  = r_cnt[c] + CNT_WIDTH'(w_pop[c]);
      // Completion includes the pops happening in this very cycle.
      if (w_cnt_nxt[c] != r_len)
        w_all_done = 1'b0;
    end
  end

  assign bus.push_ready = w_push_rdy;
  assign bus.pop_valid  = w_pop_vld;
  assign bus.pop_data   = w_pop_data;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign busy_o         = r_busy;
  assign done_o         = r_done;

  // Storage write stage (data is not reset; pointers define validity)
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NB_CH; c++) begin
      if (w_wr[c])
        r_mem[c][r_wptr[c]] <= bus.push_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Pointer and occupancy stage
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int c = 0; c < NB_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_occ[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NB_CH; c++) begin
        if (w_wr[c]) r_wptr[c] <= r_wptr[c] + AW'(1);
        if (w_rd[c]) r_rptr[c] <= r_rptr[c] + AW'(1);
        r_occ[c] <= r_occ[c] + (AW+1)'(w_wr[c]) - (AW+1)'(w_rd[c]);
      end
    end
  end

  // Job controller stage
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_len   <= '0;
      for (int c = 0; c < NB_CH; c++) r_cnt[c] <= '0;
    end else if (enable_i) begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_len <= len_i;
            for (int c = 0; c < NB_CH; c++) r_cnt[c] <= '0;
            if (len_i != '0) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          for (int c = 0; c < NB_CH; c++) r_cnt[c] <= w_cnt_nxt[c];
          if (w_all_done) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_dataflow_stream_fifo_bank.sv
// ----------------------------------------------------------------------------
// tb_multi_dataflow_stream_fifo_bank
// Directed bench for the multi_dataflow stream FIFO bank (NB_CH=3, 32-bit,
// depth 4). Inputs are driven 1 time unit after the rising edge and outputs
// are sampled 1 time unit later, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_multi_dataflow_stream_fifo_bank;
  localparam int NB = 3;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, clear, enable, start;
  logic [CW-1:0] len;
  logic [NB-1:0] full, empty;
  logic          busy, done;
  int            checks   = 0;
  int            failures = 0;

  multi_dataflow_stream_fifo_bank_if #(.NB_CH(NB), .DATA_WIDTH(DW)) bus ();

  multi_dataflow_stream_fifo_bank #(
    .NB_CH(NB), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .CNT_WIDTH(CW)
  ) u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .enable_i(enable),
    .start_i (start),
    .len_i   (len),
    .bus     (bus),
    .full_o  (full),
    .empty_o (empty),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start          = 1'b0;
    clear          = 1'b0;
    bus.push_valid = '0;
    bus.pop_ready  = '0;
    bus.push_data  = '0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.push_data  = {$urandom, $urandom, $urandom};
      bus.push_valid = 3'($urandom);
      bus.pop_ready  = 3'($urandom);
      start          = 1'($urandom);
      clear          = 1'($urandom);
      len            = 16'($urandom);
      step();
    end
    checks++; if (bus.push_ready !== 3'b111) begin failures++; $display("FAIL reset_push_ready got=%b exp=111", bus.push_ready); end
    checks++; if (bus.pop_valid !== 3'b000) begin failures++; $display("FAIL reset_pop_valid got=%b exp=000", bus.pop_valid); end
    checks++; if (bus.pop_data !== '0) begin failures++; $display("FAIL reset_pop_data got=%h exp=0", bus.pop_data); end
    checks++; if (empty !== 3'b111) begin failures++; $display("FAIL reset_empty got=%b exp=111", empty); end
    checks++; if (full !== 3'b000) begin failures++; $display("FAIL reset_full got=%b exp=000", full); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_fill();
    int n;
    for (int i = 0; i < 5; i++) begin
      bus.push_data[0 +: DW] = 32'(i + 1);
      bus.push_valid         = 3'b001;
      #1;
      checks++; if (bus.push_ready[0] !== (i < 4)) begin failures++; $display("FAIL fill_ready_%0d got=%b exp=%b", i, bus.push_ready[0], (i < 4)); end
      step();
    end
    bus.push_valid = '0;
    #1;
    checks++; if (full !== 3'b001) begin failures++; $display("FAIL fill_full got=%b exp=001", full); end
    checks++; if (empty !== 3'b110) begin failures++; $display("FAIL fill_empty got=%b exp=110", empty); end
    checks++; if (bus.push_ready !== 3'b110) begin failures++; $display("FAIL fill_push_ready got=%b exp=110", bus.push_ready); end
    checks++; if (bus.pop_valid !== 3'b000) begin failures++; $display("FAIL fill_pop_idle got=%b exp=000", bus.pop_valid); end
    // Drain channel 0: must deliver 1..4, proving the refused 5th word was not stored
    len   = 16'd4;
    start = 1'b1;
    step();
    start         = 1'b0;
    bus.pop_ready = 3'b001;
    n             = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (bus.pop_valid[0] && bus.pop_ready[0]) begin
        checks++; if (bus.pop_data[0 +: DW] !== 32'(n + 1)) begin failures++; $display("FAIL fill_drain_%0d got=%0d exp=%0d", n, bus.pop_data[0 +: DW], n + 1); end
        n++;
      end
      step();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL fill_drain_count got=%0d exp=4", n); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fill_still_running got=%b exp=1", busy); end
    clear = 1'b1;
    bus.pop_ready = '0;
    step();
    clear = 1'b0;
    #1;
    checks++; if (empty !== 3'b111) begin failures++; $display("FAIL fill_clear_empty got=%b exp=111", empty); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fill_clear_busy got=%b exp=0", busy); end
  endtask

  task automatic test_job();
    int k, nd;
    int np [NB];
    len   = 16'd6;
    start = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL job_busy_before got=%b exp=0", busy); end
    step();
    start = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL job_busy_run got=%b exp=1", busy); end
    k  = 0;
    nd = 0;
    for (int c = 0; c < NB; c++) np[c] = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.pop_ready = 3'b111;
      if (k < 8) begin
        bus.push_valid = 3'b111;
        for (int c = 0; c < NB; c++) bus.push_data[c*DW +: DW] = 32'(c*256 + k);
      end else begin
        bus.push_valid = 3'b000;
      end
      #1;
      for (int c = 0; c < NB; c++) begin
        if (bus.pop_valid[c] && bus.pop_ready[c]) begin
          checks++; if (bus.pop_data[c*DW +: DW] !== 32'(c*256 + np[c])) begin failures++; $display("FAIL job_data_ch%0d got=%0d exp=%0d", c, bus.pop_data[c*DW +: DW], c*256 + np[c]); end
          np[c]++;
        end
      end
      if (done === 1'b1) nd++;
      if (k < 8 && bus.push_ready === 3'b111) k++;
      step();
    end
    idle_inputs();
    #1;
    for (int c = 0; c < NB; c++) begin
      checks++; if (np[c] != 6) begin failures++; $display("FAIL job_pop_count_ch%0d got=%0d exp=6", c, np[c]); end
    end
    checks++; if (nd != 1) begin failures++; $display("FAIL job_done_pulses got=%0d exp=1", nd); end
    checks++; if (empty !== 3'b000) begin failures++; $display("FAIL job_leftover_empty got=%b exp=000", empty); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL job_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_zero_len();
    bus.pop_ready = 3'b111;
    len   = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy); end
    checks++; if (bus.pop_valid !== 3'b000) begin failures++; $display("FAIL zero_pop_valid got=%b exp=000", bus.pop_valid); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_clear got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%b exp=0", busy); end
    checks++; if (empty !== 3'b000) begin failures++; $display("FAIL zero_kept_data got=%b exp=000", empty); end
  endtask

  task automatic test_leftover();
    int nd;
    int np [NB];
    nd = 0;
    for (int c = 0; c < NB; c++) np[c] = 0;
    bus.pop_ready = 3'b111;
    len   = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      for (int c = 0; c < NB; c++) begin
        if (bus.pop_valid[c] && bus.pop_ready[c]) begin
          checks++; if (bus.pop_data[c*DW +: DW] !== 32'(c*256 + 6 + np[c])) begin failures++; $display("FAIL left_data_ch%0d got=%0d exp=%0d", c, bus.pop_data[c*DW +: DW], c*256 + 6 + np[c]); end
          np[c]++;
        end
      end
      if (done === 1'b1) nd++;
      step();
    end
    idle_inputs();
    #1;
    checks++; if (np[0] + np[1] + np[2] != 6) begin failures++; $display("FAIL left_pop_total got=%0d exp=6", np[0] + np[1] + np[2]); end
    checks++; if (nd != 1) begin failures++; $display("FAIL left_done_pulses got=%0d exp=1", nd); end
    checks++; if (empty !== 3'b111) begin failures++; $display("FAIL left_empty got=%b exp=111", empty); end
  endtask

  task automatic test_clear_mid_job();
    int k, np0, nd;
    int np [NB];
    len   = 16'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    k   = 0;
    np0 = 0;
    nd  = 0;
    for (int cyc = 0; cyc < 20 && np0 < 4; cyc++) begin
      bus.pop_ready  = 3'b111;
      bus.push_valid = 3'b111;
      for (int c = 0; c < NB; c++) bus.push_data[c*DW +: DW] = 32'(c*256 + k);
      #1;
      if (bus.pop_valid[0] && bus.pop_ready[0]) np0++;
      if (done === 1'b1) nd++;
      if (bus.push_ready === 3'b111) k++;
      step();
    end
    checks++; if (np0 != 4) begin failures++; $display("FAIL clr_pops_before got=%0d exp=4", np0); end
    idle_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", busy); end
    checks++; if (empty !== 3'b111) begin failures++; $display("FAIL clr_empty got=%b exp=111", empty); end
    checks++; if (bus.pop_valid !== 3'b000) begin failures++; $display("FAIL clr_pop_valid got=%b exp=000", bus.pop_valid); end
    if (done === 1'b1) nd++;
    step();
    if (done === 1'b1) nd++;
    checks++; if (nd != 0) begin failures++; $display("FAIL clr_no_done got=%0d exp=0", nd); end
    // Restart: prefetch two words per channel while idle, then run len=2
    for (int i = 0; i < 2; i++) begin
      bus.push_valid = 3'b111;
      for (int c = 0; c < NB; c++) bus.push_data[c*DW +: DW] = 32'(c*256 + 100 + i);
      step();
    end
    bus.push_valid = '0;
    bus.pop_ready  = 3'b111;
    len   = 16'd2;
    start = 1'b1;
    #1;
    checks++; if (bus.pop_valid !== 3'b000) begin failures++; $display("FAIL clr_idle_no_pop got=%b exp=000", bus.pop_valid); end
    step();
    start = 1'b0;
    for (int c = 0; c < NB; c++) np[c] = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      for (int c = 0; c < NB; c++) begin
        if (bus.pop_valid[c] && bus.pop_ready[c]) begin
          checks++; if (bus.pop_data[c*DW +: DW] !== 32'(c*256 + 100 + np[c])) begin failures++; $display("FAIL clr_restart_data_ch%0d got=%0d exp=%0d", c, bus.pop_data[c*DW +: DW], c*256 + 100 + np[c]); end
          np[c]++;
        end
      end
      if (done === 1'b1) nd++;
      step();
    end
    idle_inputs();
    #1;
    checks++; if (np[0] + np[1] + np[2] != 6) begin failures++; $display("FAIL clr_restart_pops got=%0d exp=6", np[0] + np[1] + np[2]); end
    checks++; if (nd != 1) begin failures++; $display("FAIL clr_restart_done got=%0d exp=1", nd); end
    checks++; if (empty !== 3'b111) begin failures++; $display("FAIL clr_restart_empty got=%b exp=111", empty); end
  endtask

  task automatic test_fallthrough();
    len   = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    bus.push_data[0 +: DW] = 32'hA5;
    bus.push_valid         = 3'b001;
    bus.pop_ready          = 3'b001;
    #1;
`ifdef MDC_FIFO_BANK_FALLTHROUGH_EN
    checks++; if (bus.pop_valid[0] !== 1'b1) begin failures++; $display("FAIL ft_same_cycle_valid got=%b exp=1", bus.pop_valid[0]); end
    checks++; if (bus.pop_data[0 +: DW] !== 32'hA5) begin failures++; $display("FAIL ft_same_cycle_data got=%h exp=a5", bus.pop_data[0 +: DW]); end
    step();
    bus.push_valid = '0;
    #1;
    checks++; if (empty[0] !== 1'b1) begin failures++; $display("FAIL ft_bypass_empty got=%b exp=1", empty[0]); end
    checks++; if (bus.pop_valid[0] !== 1'b0) begin failures++; $display("FAIL ft_quota_closed got=%b exp=0", bus.pop_valid[0]); end
`else
    checks++; if (bus.pop_valid[0] !== 1'b0) begin failures++; $display("FAIL ft_no_bypass_valid got=%b exp=0", bus.pop_valid[0]); end
    step();
    bus.push_valid = '0;
    #1;
    checks++; if (bus.pop_valid[0] !== 1'b1) begin failures++; $display("FAIL ft_next_cycle_valid got=%b exp=1", bus.pop_valid[0]); end
    checks++; if (bus.pop_data[0 +: DW] !== 32'hA5) begin failures++; $display("FAIL ft_next_cycle_data got=%h exp=a5", bus.pop_data[0 +: DW]); end
    step();
    checks++; if (empty[0] !== 1'b1) begin failures++; $display("FAIL ft_drained_empty got=%b exp=1", empty[0]); end
`endif
    idle_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst    = 1'b1;
    enable = 1'b1;
    len    = '0;
    test_reset();
    test_fill();
    test_job();
    test_zero_len();
    test_leftover();
    test_clear_mid_job();
    test_fallthrough();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
